// File: rtl/lamp_sequencer.sv
// Four-approach traffic lamp sequencer.
// Each approach runs its own RED -> GREEN -> AMBER -> ALLRED -> RED cycle.
// Only one approach may be out of RED at a time. Grants seen on more than
// one approach latch a sticky conflict flag that blocks new greens until reset.
//
//   state  | meaning
//   RED    | idle, red lit, may be granted green
//   GREEN  | arrows follow registered LG/SG/RG bits
//   AMBER  | amber lit, counting AMBER_TICKS ticks
//   ALLRED | red lit, clearance of ALLRED_TICKS ticks
module lamp_sequencer #(
    parameter int AMBER_TICKS  = 3,
    parameter int ALLRED_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] LG,
    input  logic [3:0] SG,
    input  logic [3:0] RG,
    output logic [3:0] lamp_red,
    output logic [3:0] lamp_amber,
    output logic [3:0] lamp_gl,
    output logic [3:0] lamp_gs,
    output logic [3:0] lamp_gr,
    output logic       clear,
    output logic       conflict_err
);

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        AMBER  = 2'd2,
        ALLRED = 2'd3
    } state_t;

    localparam logic [3:0] AMBER_LOAD  = 4'(AMBER_TICKS);
    localparam logic [3:0] ALLRED_LOAD = 4'(ALLRED_TICKS);

    state_t     state     [4];
    state_t     state_nxt [4];
    logic [3:0] cnt       [4];
    logic [3:0] cnt_nxt   [4];
    logic [3:0] lg_q, sg_q, rg_q;
    logic [3:0] g;
    logic [3:0] is_red;
    logic [3:0] is_green;
    logic       multi_grant;
    logic       conflict_set;

    assign g           = LG | SG | RG;
    assign multi_grant = (g & (g - 4'd1)) != 4'd0;

    // Per-approach state flags used by the cross-approach interlocks.
    always_comb begin
        is_red   = 4'b0;
        is_green = 4'b0;
        for (int i = 0; i < 4; i++) begin
            is_red[i]   = (state[i] == RED);
            is_green[i] = (state[i] == GREEN);
        end
    end

    // Conflict: several grants while all idle, or a foreign grant during a green.
    always_comb begin
        conflict_set = 1'b0;
        if ((&is_red) && multi_grant)
            conflict_set = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (is_green[i] && ((g & ~(4'b0001 << i)) != 4'd0))
                conflict_set = 1'b1;
        end
    end

    // Next-state and counter logic for each approach FSM.
    always_comb begin
        logic [3:0] mask;
        logic       other_g;
        logic       others_red;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            mask         = 4'b0001 << i;
            other_g      = (g & ~mask) != 4'd0;
            others_red   = &(is_red | mask);
            case (state[i])
                RED: begin
                    if (g[i] && others_red && !other_g && !conflict_err)
                        state_nxt[i] = GREEN;
                end
                GREEN: begin
                    if (!g[i] || other_g) begin
                        state_nxt[i] = AMBER;
                        cnt_nxt[i]   = AMBER_LOAD;
                    end
                end
                AMBER: begin
                    if (tick) begin
                        if (cnt[i] <= 4'd1) begin
                            state_nxt[i] = ALLRED;
                            cnt_nxt[i]   = ALLRED_LOAD;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 4'd1;
                        end
                    end
                end
                ALLRED: begin
                    if (tick) begin
                        if (cnt[i] <= 4'd1) begin
                            state_nxt[i] = RED;
                            cnt_nxt[i]   = 4'd0;
                        end else begin
                            cnt_nxt[i] = cnt[i] - 4'd1;
                        end
                    end
                end
                default: state_nxt[i] = RED;
            endcase
        end
    end

    // State, counter, arrow sample and sticky conflict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= RED;
                cnt[i]   <= 4'd0;
            end
            lg_q         <= 4'b0;
            sg_q         <= 4'b0;
            rg_q         <= 4'b0;
            conflict_err <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            lg_q <= LG;
            sg_q <= SG;
            rg_q <= RG;
            if (conflict_set)
                conflict_err <= 1'b1;
        end
    end

    // Moore lamp decode from the state registers.
    always_comb begin
        lamp_red   = 4'b0;
        lamp_amber = 4'b0;
        lamp_gl    = 4'b0;
        lamp_gs    = 4'b0;
        lamp_gr    = 4'b0;
        for (int i = 0; i < 4; i++) begin
            lamp_red[i]   = (state[i] == RED) || (state[i] == ALLRED);
            lamp_amber[i] = (state[i] == AMBER);
            lamp_gl[i]    = is_green[i] && lg_q[i];
            lamp_gs[i]    = is_green[i] && sg_q[i];
            lamp_gr[i]    = is_green[i] && rg_q[i];
        end
    end

    assign clear = &is_red;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer with AMBER_TICKS=3, ALLRED_TICKS=2.
module tb_lamp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] LG, SG, RG;
    logic [3:0] lamp_red, lamp_amber, lamp_gl, lamp_gs, lamp_gr;
    logic       clear, conflict_err;

    int n_checks = 0;
    int n_errors = 0;

    lamp_sequencer #(.AMBER_TICKS(3), .ALLRED_TICKS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .LG           (LG),
        .SG           (SG),
        .RG           (RG),
        .lamp_red     (lamp_red),
        .lamp_amber   (lamp_amber),
        .lamp_gl      (lamp_gl),
        .lamp_gs      (lamp_gs),
        .lamp_gr      (lamp_gr),
        .clear        (clear),
        .conflict_err (conflict_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Lamp invariants on every cycle: exactly one lamp class per approach,
    // and at most one approach showing green or amber.
    always @(negedge clk) begin
        int active;
        int classes;
        if (rst !== 1'b1 && rst !== 1'b0) begin
            // inputs not yet driven
        end else begin
            active = 0;
            for (int i = 0; i < 4; i++) begin
                classes = int'(lamp_red[i]) + int'(lamp_amber[i])
                        + int'(lamp_gl[i] | lamp_gs[i] | lamp_gr[i]);
                check($sformatf("one_class[%0d]", i), classes, 1);
                if (lamp_amber[i] || lamp_gl[i] || lamp_gs[i] || lamp_gr[i])
                    active++;
            end
            check("one_active", 32'(active <= 1), 1);
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; LG = 4'b0; SG = 4'b0; RG = 4'b0;
        step();
        step();
        check("rst_red",      lamp_red,     4'b1111);
        check("rst_amber",    lamp_amber,   4'b0000);
        check("rst_greens",   {lamp_gl, lamp_gs, lamp_gr}, 12'h000);
        check("rst_clear",    clear,        1'b1);
        check("rst_conflict", conflict_err, 1'b0);

        // Grant approach 0 left+straight
        rst = 1'b0; LG = 4'b0001; SG = 4'b0001;
        step();
        check("g0_gl",    lamp_gl,  4'b0001);
        check("g0_gs",    lamp_gs,  4'b0001);
        check("g0_gr",    lamp_gr,  4'b0000);
        check("g0_red",   lamp_red, 4'b1110);
        check("g0_clear", clear,    1'b0);

        // Arrow bits change while still granted
        LG = 4'b0000; RG = 4'b0001;
        step();
        check("arrow_gl", lamp_gl, 4'b0000);
        check("arrow_gs", lamp_gs, 4'b0001);
        check("arrow_gr", lamp_gr, 4'b0001);

        // Drop grant with a tick in the entry cycle (must not count)
        SG = 4'b0000; RG = 4'b0000; tick = 1'b1;
        step();
        tick = 1'b0;
        check("amb_entry", lamp_amber, 4'b0001);
        check("amb_entry_red", lamp_red, 4'b1110);

        // Approach 1 requests during amber of approach 0
        SG = 4'b0010;
        step();
        check("amb_idle", lamp_amber, 4'b0001);
        check("wait1_red", lamp_red, 4'b1110);
        pulse_tick();
        check("amb_t1", lamp_amber, 4'b0001);
        pulse_tick();
        check("amb_t2", lamp_amber, 4'b0001);
        step();
        check("amb_t2_idle", lamp_amber, 4'b0001);
        pulse_tick();
        check("allred_amber", lamp_amber, 4'b0000);
        check("allred_red",   lamp_red,   4'b1111);
        check("allred_clear", clear,      1'b0);
        pulse_tick();
        check("allred_t1_clear", clear, 1'b0);
        check("allred_t1_gs",    lamp_gs, 4'b0000);
        pulse_tick();
        check("red0_clear", clear,    1'b1);
        check("red0_red",   lamp_red, 4'b1111);
        step();
        check("g1_gs",    lamp_gs,  4'b0010);
        check("g1_red",   lamp_red, 4'b1101);
        check("g1_clear", clear,    1'b0);

        // Finish approach 1
        SG = 4'b0000;
        step();
        check("amb1", lamp_amber, 4'b0010);
        repeat (5) pulse_tick();
        check("seq1_clear", clear, 1'b1);

        // Foreign grant during a green forces amber and flags conflict
        SG = 4'b0100;
        step();
        check("g2_gs", lamp_gs, 4'b0100);
        LG = 4'b0001;
        step();
        check("cfl_err",   conflict_err, 1'b1);
        check("cfl_amber", lamp_amber,   4'b0100);
        check("cfl_gl",    lamp_gl,      4'b0000);

        // Reset mid-amber with tick and grants present
        rst = 1'b1; tick = 1'b1;
        step();
        rst = 1'b0; tick = 1'b0; LG = 4'b0000; SG = 4'b0000;
        check("rst2_red",      lamp_red,     4'b1111);
        check("rst2_amber",    lamp_amber,   4'b0000);
        check("rst2_clear",    clear,        1'b1);
        check("rst2_conflict", conflict_err, 1'b0);
        step();

        // Simultaneous grants from all-red
        SG = 4'b0011;
        step();
        check("multi_err",    conflict_err, 1'b1);
        check("multi_red",    lamp_red,     4'b1111);
        check("multi_greens", {lamp_gl, lamp_gs, lamp_gr}, 12'h000);
        SG = 4'b0001;
        repeat (3) step();
        check("blocked_gs",  lamp_gs,      4'b0000);
        check("blocked_err", conflict_err, 1'b1);
        check("blocked_red", lamp_red,     4'b1111);

        // Only reset clears the conflict
        SG = 4'b0000; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst3_conflict", conflict_err, 1'b0);
        RG = 4'b1000;
        step();
        check("g3_gr",  lamp_gr,  4'b1000);
        check("g3_red", lamp_red, 4'b0111);
        RG = 4'b0000;
        step();
        check("amb3", lamp_amber, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
